debug_unit: RTL and testbench
=============================

Name: debug_unit

Overview:
- Host-side controller for the `mips` pipeline. It drives the core's `i_stall` input, loads instruction memory and reads back register-file and data-memory contents.
- Consumes command bytes from a byte-stream receiver and produces response bytes to a byte-stream transmitter (valid/ready).
- Sits at top level beside `mips`; it is the initiator of the stall/program/debug-read interface the core responds to.

Parameters:
- SIZE, 32, data word width (core datapath width)
- NUM_REGISTERS, 32, register-file entries dumped by DUMP_REGS
- IMEM_ADDR_W, 8, instruction-memory word-address width
- DMEM_ADDR_W, 8, data-memory word-address width
- DUMP_MEM_WORDS, 32, words sent by DUMP_MEM, starting at word 0

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-low reset
- i_rx_data  in  8  command/payload byte
- i_rx_valid  in  1  one-cycle strobe; i_rx_data valid
- o_tx_data  out  8  response byte
- o_tx_valid  out  1  response byte valid; held until accepted
- i_tx_ready  in  1  transmitter accepts when o_tx_valid & i_tx_ready
- o_stall  out  1  drives core `i_stall`
- o_core_rst  out  1  core reset request, active-high, one-cycle pulse
- i_halt  in  1  core retired HALT instruction
- o_imem_we  out  1  instruction-memory write strobe
- o_imem_addr  out  IMEM_ADDR_W  word address
- o_imem_wdata  out  SIZE  instruction word
- o_dbg_reg_addr  out  $clog2(NUM_REGISTERS)  register read address
- i_dbg_reg_data  in  SIZE  register data, valid 1 cycle after the address is presented
- o_dbg_mem_addr  out  DMEM_ADDR_W  data-memory read address
- i_dbg_mem_data  in  SIZE  memory data, valid 1 cycle after the address is presented
- o_rx_drop  out  1  one-cycle pulse: a byte arrived while busy and was discarded

Behaviour:
- Reset (rst=0, async): state IDLE; o_stall=1 (core frozen); all other outputs and counters 0.
- Commands (first byte seen in IDLE):
  - 0x01 LOAD
  - 0x02 RUN
  - 0x03 STEP
  - 0x04 DUMP_REGS
  - 0x05 DUMP_MEM
  - 0x06 CORE_RST
  - any other byte → send 0xEE, return to IDLE.
- LOAD:
  - Next byte N = word count. Then 4N bytes, MSB first.
  - After each 4th byte: one-cycle o_imem_we with addr = word index (starts 0, wraps mod 2^IMEM_ADDR_W).
  - After the last word, send ACK 0xAA. N=0 sends ACK immediately.
  - o_stall stays 1 throughout.
- RUN:
  - o_stall=0 from the cycle after the command byte.
  - Each cycle i_halt=1 is sampled, o_stall=1 on the next edge, then ACK 0xAA.
  - If i_halt is already 1 on entry, exactly one unstalled cycle occurs, then the stall and ACK.
- STEP: o_stall=0 for exactly one cycle, then 1; then ACK 0xAA.
- DUMP_REGS: for r = 0..NUM_REGISTERS-1, present the address, capture data on the next cycle, send 4 bytes MSB first. No ACK byte; total 4·NUM_REGISTERS bytes.
- DUMP_MEM: same as DUMP_REGS over words 0..DUMP_MEM_WORDS-1 on the dmem port. o_stall stays 1.
- CORE_RST: o_core_rst=1 for one cycle; o_stall=1; then ACK 0xAA.
- TX handshake:
  - o_tx_data and o_tx_valid are held stable until i_tx_ready.
  - The next byte is presented no earlier than the cycle after acceptance.
  - Backpressure stalls dump progress indefinitely.
- RX: no ready signal. A byte with i_rx_valid outside IDLE and the LOAD payload states is dropped and o_rx_drop pulses.
- State machine states: IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, RUN, STEP, RD_ADDR, RD_CAP, TX_BYTE, SEND_ACK, CORE_RST.
- Reset mid-operation: abort immediately to reset values. Partial LOAD words are discarded; no ACK is sent.
- o_imem_we and o_core_rst are never asserted in the same cycle.

Decomposition:
- Shared package `debug_pkg`:
  - command opcodes (CMD_LOAD … CMD_CORE_RST)
  - RSP_ACK=8'hAA, RSP_ERR=8'hEE
  - state enum encoding
- One natural sub-module, `word_serializer`: a SIZE→byte shifter with tx handshake, shared by both dump paths and by the ACK/ERR send.

Test Plan:
- Reset then idle 10 cycles → o_stall=1, o_tx_valid=0, o_imem_we=0.
- Send 01,02,DE,AD,BE,EF,00,00,00,13 → o_imem_we pulses with (addr 0, 0xDEADBEEF) and (addr 1, 0x00000013); then tx 0xAA; o_stall=1 throughout.
- Send 02; raise i_halt 7 cycles later → o_stall=0 for exactly 7 cycles, then 1; tx 0xAA.
- Send 03 → o_stall=0 for exactly 1 cycle; tx 0xAA. Send 0x7F → tx 0xEE.
- Send 04 with reg r returning 0x01000000+r, i_tx_ready toggling every other cycle → 128 bytes; first four are 01,00,00,00, last four are 01,00,00,1F; no byte lost or duplicated.
- Send 05 then a byte mid-dump → o_rx_drop=1 once; dump completes. Assert rst mid-LOAD → o_imem_we stays 0; no ACK; o_stall=1.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared opcodes, response codes and FSM encoding for the debug unit.
package debug_pkg;
  localparam logic [7:0] CMD_LOAD      = 8'h01;
  localparam logic [7:0] CMD_RUN       = 8'h02;
  localparam logic [7:0] CMD_STEP      = 8'h03;
  localparam logic [7:0] CMD_DUMP_REGS = 8'h04;
  localparam logic [7:0] CMD_DUMP_MEM  = 8'h05;
  localparam logic [7:0] CMD_CORE_RST  = 8'h06;

  localparam logic [7:0] RSP_ACK = 8'hAA;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_CNT, S_LOAD_BYTE, S_LOAD_WR, S_RUN, S_STEP,
    S_RD_ADDR, S_RD_CAP, S_TX_BYTE, S_SEND_ACK, S_CORE_RST
  } state_e;
endpackage

// File: rtl/debug_unit_word_serializer.sv
// Word-to-byte shifter, MSB first, with valid/ready handshake.
// Loaded with a word and a byte count; done pulses on the last accepted byte.
module word_serializer #(
  parameter int SIZE = 32,
  parameter int CW   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [SIZE-1:0] word,
  input  logic [CW-1:0]   nbytes,
  input  logic            tx_ready,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  output logic            done
);
  logic [SIZE-1:0] sreg;
  logic [CW-1:0]   cnt;
  logic            vld;
  logic            accept;

  assign accept   = vld & tx_ready;
  assign tx_data  = sreg[SIZE-1 -: 8];
  assign tx_valid = vld;
  assign done     = accept && (cnt == CW'(1));

  // Shift register: hold byte until accepted, then expose the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= '0;
      cnt  <= '0;
      vld  <= 1'b0;
    end else if (load) begin
      sreg <= word;
      cnt  <= nbytes;
      vld  <= (nbytes != '0);
    end else if (accept) begin
      sreg <= sreg << 8;
      cnt  <= cnt - CW'(1);
      vld  <= (cnt != CW'(1));
    end
  end
endmodule

// File: rtl/debug_unit.sv
// Host-side debug controller for the mips core: program load, run/step
// control, register/data-memory dumps over a byte stream.
module debug_unit
  import debug_pkg::*;
#(
  parameter int SIZE           = 32,
  parameter int NUM_REGISTERS  = 32,
  parameter int IMEM_ADDR_W    = 8,
  parameter int DMEM_ADDR_W    = 8,
  parameter int DUMP_MEM_WORDS = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [7:0]                       i_rx_data,
  input  logic                             i_rx_valid,
  output logic [7:0]                       o_tx_data,
  output logic                             o_tx_valid,
  input  logic                             i_tx_ready,
  output logic                             o_stall,
  output logic                             o_core_rst,
  input  logic                             i_halt,
  output logic                             o_imem_we,
  output logic [IMEM_ADDR_W-1:0]           o_imem_addr,
  output logic [SIZE-1:0]                  o_imem_wdata,
  output logic [$clog2(NUM_REGISTERS)-1:0] o_dbg_reg_addr,
  input  logic [SIZE-1:0]                  i_dbg_reg_data,
  output logic [DMEM_ADDR_W-1:0]           o_dbg_mem_addr,
  input  logic [SIZE-1:0]                  i_dbg_mem_data,
  output logic                             o_rx_drop
);
  localparam int NB   = SIZE / 8;
  localparam int BW   = $clog2(NB);
  localparam int CW   = $clog2(NB) + 1;
  localparam int MAXW = (NUM_REGISTERS > DUMP_MEM_WORDS) ? NUM_REGISTERS : DUMP_MEM_WORDS;
  localparam int RD_W = $clog2(MAXW) + 1;
  localparam int RAW  = $clog2(NUM_REGISTERS);

  state_e                 state, nxt;
  logic [7:0]             words_left;
  logic [BW-1:0]          byte_idx;
  logic [SIZE-1:0]        wbuf;
  logic [IMEM_ADDR_W-1:0] imem_addr;
  logic [RD_W-1:0]        rd_idx;
  logic                   mem_sel, in_dump, stall, rx_drop;
  logic [7:0]             rsp;
  logic                   rx_take, rd_last;
  logic                   ser_load, ser_done;
  logic [SIZE-1:0]        ser_word;
  logic [CW-1:0]          ser_n;

  // A LOAD_WR cycle still accepts payload unless it is writing the final word.
  assign rx_take = i_rx_valid && (state == S_IDLE || state == S_LOAD_CNT ||
                   state == S_LOAD_BYTE || (state == S_LOAD_WR && words_left != 8'd1));
  assign rd_last = mem_sel ? (rd_idx == RD_W'(DUMP_MEM_WORDS - 1))
                           : (rd_idx == RD_W'(NUM_REGISTERS - 1));

  assign o_stall        = stall;
  assign o_rx_drop      = rx_drop;
  assign o_imem_addr    = imem_addr;
  assign o_imem_wdata   = wbuf;
  assign o_dbg_reg_addr = RAW'(rd_idx);
  assign o_dbg_mem_addr = DMEM_ADDR_W'(rd_idx);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  // Next-state decode.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (i_rx_valid) begin
        case (i_rx_data)
          CMD_LOAD:                    nxt = S_LOAD_CNT;
          CMD_RUN:                     nxt = S_RUN;
          CMD_STEP:                    nxt = S_STEP;
          CMD_DUMP_REGS, CMD_DUMP_MEM: nxt = S_RD_ADDR;
          CMD_CORE_RST:                nxt = S_CORE_RST;
          default:                     nxt = S_SEND_ACK;
        endcase
      end
      S_LOAD_CNT:  if (i_rx_valid) nxt = (i_rx_data == 8'd0) ? S_SEND_ACK : S_LOAD_BYTE;
      S_LOAD_BYTE: if (i_rx_valid && byte_idx == BW'(NB - 1)) nxt = S_LOAD_WR;
      S_LOAD_WR:   nxt = (words_left == 8'd1) ? S_SEND_ACK : S_LOAD_BYTE;
      S_RUN:       if (i_halt) nxt = S_SEND_ACK;
      S_STEP:      nxt = S_SEND_ACK;
      S_CORE_RST:  nxt = S_SEND_ACK;
      S_SEND_ACK:  nxt = S_TX_BYTE;
      S_RD_ADDR:   nxt = S_RD_CAP;
      S_RD_CAP:    nxt = S_TX_BYTE;
      S_TX_BYTE:   if (ser_done) nxt = (in_dump && !rd_last) ? S_RD_ADDR : S_IDLE;
      default:     nxt = S_IDLE;
    endcase
  end

  // Per-state strobes and serializer load selection.
  always_comb begin
    o_imem_we  = (state == S_LOAD_WR);
    o_core_rst = (state == S_CORE_RST);
    ser_load   = (state == S_SEND_ACK) || (state == S_RD_CAP);
    if (state == S_RD_CAP) begin
      ser_word = mem_sel ? i_dbg_mem_data : i_dbg_reg_data;
      ser_n    = CW'(NB);
    end else begin
      ser_word = {rsp, {(SIZE-8){1'b0}}};
      ser_n    = CW'(1);
    end
  end

  // Datapath: load assembly, dump index, stall control, drop pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      words_left <= '0;
      byte_idx   <= '0;
      wbuf       <= '0;
      imem_addr  <= '0;
      rd_idx     <= '0;
      mem_sel    <= 1'b0;
      in_dump    <= 1'b0;
      rsp        <= '0;
      stall      <= 1'b1;
      rx_drop    <= 1'b0;
    end else begin
      rx_drop <= i_rx_valid && !rx_take;
      case (state)
        S_IDLE: if (i_rx_valid) begin
          rsp     <= (i_rx_data >= CMD_LOAD && i_rx_data <= CMD_CORE_RST) ? RSP_ACK : RSP_ERR;
          in_dump <= (i_rx_data == CMD_DUMP_REGS) || (i_rx_data == CMD_DUMP_MEM);
          mem_sel <= (i_rx_data == CMD_DUMP_MEM);
          stall   <= !((i_rx_data == CMD_RUN) || (i_rx_data == CMD_STEP));
          rd_idx  <= '0;
        end
        S_LOAD_CNT: if (i_rx_valid) begin
          words_left <= i_rx_data;
          imem_addr  <= '0;
          byte_idx   <= '0;
        end
        S_LOAD_BYTE: if (i_rx_valid) begin
          wbuf     <= {wbuf[SIZE-9:0], i_rx_data};
          byte_idx <= byte_idx + BW'(1);
        end
        S_LOAD_WR: begin
          imem_addr  <= imem_addr + IMEM_ADDR_W'(1);
          words_left <= words_left - 8'd1;
          if (rx_take) begin
            wbuf     <= {wbuf[SIZE-9:0], i_rx_data};
            byte_idx <= byte_idx + BW'(1);
          end
        end
        S_RUN:     if (i_halt) stall <= 1'b1;
        S_STEP:    stall <= 1'b1;
        S_TX_BYTE: if (ser_done && in_dump && !rd_last) rd_idx <= rd_idx + RD_W'(1);
        default: ;
      endcase
    end
  end

  word_serializer #(.SIZE(SIZE), .CW(CW)) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .word     (ser_word),
    .nbytes   (ser_n),
    .tx_ready (i_tx_ready),
    .tx_data  (o_tx_data),
    .tx_valid (o_tx_valid),
    .done     (ser_done)
  );
endmodule

// File: tb/tb_debug_unit.sv
// Bench for debug_unit: command table, hand-written run/dump/reset
// sequences and randomized commands scored against a byte-level model.
module tb_debug_unit;
  import debug_pkg::*;
  localparam int SIZE = 32, NREG = 32, IAW = 8, DAW = 8, DMW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      i_rx_data;
  logic            i_rx_valid;
  logic [7:0]      o_tx_data;
  logic            o_tx_valid, i_tx_ready;
  logic            o_stall, o_core_rst, i_halt, o_imem_we, o_rx_drop;
  logic [IAW-1:0]  o_imem_addr;
  logic [SIZE-1:0] o_imem_wdata;
  logic [4:0]      o_dbg_reg_addr;
  logic [SIZE-1:0] i_dbg_reg_data;
  logic [DAW-1:0]  o_dbg_mem_addr;
  logic [SIZE-1:0] i_dbg_mem_data;

  always #5 clk = ~clk;

  debug_unit #(.SIZE(SIZE), .NUM_REGISTERS(NREG), .IMEM_ADDR_W(IAW),
               .DMEM_ADDR_W(DAW), .DUMP_MEM_WORDS(DMW)) dut (
    .clk(clk), .rst(rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_stall(o_stall), .o_core_rst(o_core_rst), .i_halt(i_halt),
    .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata),
    .o_dbg_reg_addr(o_dbg_reg_addr), .i_dbg_reg_data(i_dbg_reg_data),
    .o_dbg_mem_addr(o_dbg_mem_addr), .i_dbg_mem_data(i_dbg_mem_data),
    .o_rx_drop(o_rx_drop)
  );

  // Synchronous-read register file and data memory seen by the debug port.
  logic [SIZE-1:0] dmem [2**DAW];
  always @(posedge clk) begin
    i_dbg_reg_data <= 32'h0100_0000 + 32'(o_dbg_reg_addr);
    i_dbg_mem_data <= dmem[o_dbg_mem_addr];
  end

  int n_vec = 0, n_err = 0;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Observed traffic, sampled on the falling edge.
  logic [7:0]          txq[$];
  logic [IAW+SIZE-1:0] wrq[$];
  int drops = 0, crst = 0, unst = 0, hold_err = 0, overlap = 0;
  logic pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = 8'h00;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (pv && !pr && !(o_tx_valid && o_tx_data == pd)) hold_err++;
      if (o_tx_valid && i_tx_ready) txq.push_back(o_tx_data);
      if (o_imem_we) wrq.push_back({o_imem_addr, o_imem_wdata});
      if (o_rx_drop) drops++;
      if (o_core_rst) crst++;
      if (!o_stall) unst++;
      if (o_imem_we && o_core_rst) overlap++;
    end
    pv = o_tx_valid && rst;
    pr = i_tx_ready;
    pd = o_tx_data;
  end

  // Transmitter readiness: 0 always, 1 toggling, 2 random.
  int rdy_mode = 0;
  initial begin
    i_tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       i_tx_ready = 1'b1;
        1:       i_tx_ready = ~i_tx_ready;
        default: i_tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  // Reference model: expected response bytes and imem writes for one command.
  logic [7:0]          exp_tx[$];
  logic [IAW+SIZE-1:0] exp_wr[$];
  task automatic model(input logic [7:0] cmd[$]);
    logic [SIZE-1:0] w;
    exp_tx.delete(); exp_wr.delete();
    case (cmd[0])
      CMD_LOAD: begin
        for (int i = 0; i < int'(cmd[1]); i++) begin
          w = {cmd[2+4*i], cmd[3+4*i], cmd[4+4*i], cmd[5+4*i]};
          exp_wr.push_back({IAW'(i % (2**IAW)), w});
        end
        exp_tx.push_back(8'hAA);
      end
      CMD_RUN, CMD_STEP, CMD_CORE_RST: exp_tx.push_back(8'hAA);
      CMD_DUMP_REGS, CMD_DUMP_MEM:
        for (int r = 0; r < ((cmd[0] == CMD_DUMP_REGS) ? NREG : DMW); r++) begin
          w = (cmd[0] == CMD_DUMP_REGS) ? 32'h0100_0000 + 32'(r) : dmem[r];
          for (int k = 3; k >= 0; k--) exp_tx.push_back(w[8*k +: 8]);
        end
      default: exp_tx.push_back(8'hEE);
    endcase
  endtask

  task automatic score(input string tag);
    check({tag, "_tx_count"}, 64'(txq.size()), 64'(exp_tx.size()));
    foreach (exp_tx[i]) if (i < txq.size()) check({tag, "_tx_byte"}, 64'(txq[i]), 64'(exp_tx[i]));
    check({tag, "_wr_count"}, 64'(wrq.size()), 64'(exp_wr.size()));
    foreach (exp_wr[i]) if (i < wrq.size()) check({tag, "_imem_wr"}, 64'(wrq[i]), 64'(exp_wr[i]));
  endtask

  task automatic wait_tx(input int n, input int budget);
    int t = 0;
    while (txq.size() < n && t < budget) begin tick(); t++; end
    repeat (4) tick();
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] cmd[$], input int maxgap);
    txq.delete(); wrq.delete();
    drops = 0; crst = 0; unst = 0;
    model(cmd);
    foreach (cmd[i]) send_byte(cmd[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    wait_tx(exp_tx.size(), 3000);
    score(tag);
    check({tag, "_rx_drop"}, 64'(drops), 64'd0);
  endtask

  typedef struct packed {
    logic [79:0] b;
    logic [3:0]  n;
    logic        halt;
    logic [7:0]  tx0;
    logic [7:0]  unst;
    logic [3:0]  crst;
    logic [3:0]  nwr;
  } vec_t;

  vec_t       tbl [8];
  vec_t       v;
  logic [7:0] cmd[$];
  logic [7:0] bt;
  int         nw;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{{8'h7F, 72'h0},                        4'd1,  1'b0, 8'hEE, 8'd0, 4'd0, 4'd0};
    tbl[1] = '{80'h01_02_DEADBEEF_00000013,           4'd10, 1'b0, 8'hAA, 8'd0, 4'd0, 4'd2};
    tbl[2] = '{{16'h0100, 64'h0},                     4'd2,  1'b0, 8'hAA, 8'd0, 4'd0, 4'd0};
    tbl[3] = '{{8'h03, 72'h0},                        4'd1,  1'b0, 8'hAA, 8'd1, 4'd0, 4'd0};
    tbl[4] = '{{8'h06, 72'h0},                        4'd1,  1'b0, 8'hAA, 8'd0, 4'd1, 4'd0};
    tbl[5] = '{{8'h02, 72'h0},                        4'd1,  1'b1, 8'hAA, 8'd1, 4'd0, 4'd0};
    tbl[6] = '{{8'h00, 72'h0},                        4'd1,  1'b0, 8'hEE, 8'd0, 4'd0, 4'd0};
    tbl[7] = '{{48'h0101_12345678, 32'h0},            4'd6,  1'b0, 8'hAA, 8'd0, 4'd0, 4'd1};
    for (int i = 0; i < 2**DAW; i++) dmem[i] = $urandom;

    rst = 1'b0; i_rx_data = 8'h00; i_rx_valid = 1'b0; i_halt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", 64'(o_stall), 64'd1);
    check("reset_tx_valid", 64'(o_tx_valid), 64'd0);
    rst = 1'b1;
    repeat (10) tick();
    check("idle_stall", 64'(o_stall), 64'd1);
    check("idle_tx_valid", 64'(o_tx_valid), 64'd0);
    check("idle_imem_we", 64'(o_imem_we), 64'd0);
    check("idle_core_rst", 64'(o_core_rst), 64'd0);
    check("idle_rx_drop", 64'(o_rx_drop), 64'd0);

    // Command table.
    foreach (tbl[k]) begin
      v = tbl[k];
      cmd.delete();
      for (int i = 0; i < int'(v.n); i++) begin
        bt = v.b[79-8*i -: 8];
        cmd.push_back(bt);
      end
      i_halt = v.halt;
      run_cmd("vec", cmd, 0);
      i_halt = 1'b0;
      check("vec_tx0", 64'((txq.size() > 0) ? txq[0] : 8'h00), 64'(v.tx0));
      check("vec_unstall", 64'(unst), 64'(v.unst));
      check("vec_core_rst", 64'(crst), 64'(v.crst));
      check("vec_nwr", 64'(wrq.size()), 64'(v.nwr));
      check("vec_stall_after", 64'(o_stall), 64'd1);
    end

    // RUN with halt raised on the 7th unstalled cycle.
    txq.delete(); unst = 0;
    send_byte(CMD_RUN, 0);
    repeat (6) tick();
    i_halt = 1'b1;
    wait_tx(1, 100);
    i_halt = 1'b0;
    check("run_unstall", 64'(unst), 64'd7);
    check("run_ack", 64'((txq.size() > 0) ? txq[0] : 8'h00), 64'hAA);
    check("run_stall_after", 64'(o_stall), 64'd1);

    // Register dump under toggling backpressure.
    rdy_mode = 1;
    cmd = {CMD_DUMP_REGS};
    run_cmd("dump_regs", cmd, 0);
    if (txq.size() == 128) begin
      check("dregs_first", 64'({txq[0], txq[1], txq[2], txq[3]}), 64'h0100_0000);
      check("dregs_last", 64'({txq[124], txq[125], txq[126], txq[127]}), 64'h0100_001F);
    end

    // Memory dump with a byte arriving mid-dump.
    rdy_mode = 0;
    txq.delete(); wrq.delete(); drops = 0;
    cmd = {CMD_DUMP_MEM};
    model(cmd);
    send_byte(CMD_DUMP_MEM, 0);
    repeat (5) tick();
    send_byte(8'h33, 0);
    wait_tx(exp_tx.size(), 3000);
    score("dump_mem");
    check("dump_mem_drops", 64'(drops), 64'd1);

    // Random command mix with random gaps and backpressure.
    rdy_mode = 2;
    for (int it = 0; it < 25; it++) begin
      cmd.delete();
      case ($urandom_range(0, 4))
        0, 1: begin
          nw = $urandom_range(0, 4);
          cmd.push_back(CMD_LOAD);
          cmd.push_back(8'(nw));
          for (int i = 0; i < 4*nw; i++) cmd.push_back(8'($urandom));
        end
        2: cmd.push_back($urandom_range(0, 1) ? CMD_DUMP_REGS : CMD_DUMP_MEM);
        3: cmd.push_back($urandom_range(0, 1) ? 8'($urandom_range(7, 255)) : 8'h00);
        default: cmd.push_back($urandom_range(0, 1) ? CMD_STEP : CMD_CORE_RST);
      endcase
      run_cmd("rand", cmd, 2);
    end

    // Reset in the middle of a LOAD word.
    rdy_mode = 0;
    txq.delete(); wrq.delete();
    send_byte(CMD_LOAD, 0);
    send_byte(8'h03, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hBE, 0);
    rst = 1'b0;
    #1;
    check("midrst_stall", 64'(o_stall), 64'd1);
    check("midrst_imem_we", 64'(o_imem_we), 64'd0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (10) tick();
    check("midrst_no_write", 64'(wrq.size()), 64'd0);
    check("midrst_no_ack", 64'(txq.size()), 64'd0);
    check("midrst_stall_after", 64'(o_stall), 64'd1);
    cmd = {CMD_LOAD, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    run_cmd("post_rst_load", cmd, 0);

    check("tx_hold", 64'(hold_err), 64'd0);
    check("we_core_rst_exclusive", 64'(overlap), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
